// File: rtl/mux_pipe_pkg.sv
// mux_pipe_pkg: shared types, constants and helpers for the mux_pipe block.
//   sel_width(n) : width of a channel index, never less than 1 bit
//   sel_mode_e   : channel selection mode (explicit sel or round-robin)
//   RST_DATA     : data value held by the output register after reset
package mux_pipe_pkg;

  typedef enum logic {SEL_EXPLICIT = 1'b0, SEL_RR = 1'b1} sel_mode_e;

  localparam int unsigned RST_DATA = 0;

  function automatic int sel_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mux_skid_buf.sv
// mux_skid_buf: 2-entry valid/ready skid buffer (output register + skid register).
//   clk, reset            : clock (rising edge), asynchronous active-high reset
//   in_data/in_valid/in_ready    : upstream handshake; in_ready is registered
//   out_data/out_valid/out_ready : downstream handshake; out_data is registered
// in_ready only ever reflects stored state, so there is no combinational path
// from out_ready to in_ready.
module mux_skid_buf
  import mux_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] skid_data;
  logic         skid_valid;
  logic         rdy_q;
  logic         acc;
  logic         skid_nxt;

  assign in_ready = rdy_q;
  assign acc      = in_valid && rdy_q;

  // Skid fills only when a word arrives while the output register is stalled;
  // it empties as soon as the output register pops.
  always_comb begin
    skid_nxt = 1'b0;
    if (skid_valid) skid_nxt = !out_ready;
    else            skid_nxt = acc && out_valid && !out_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data   <= W'(RST_DATA);
      out_valid  <= 1'b0;
      skid_data  <= W'(RST_DATA);
      skid_valid <= 1'b0;
      rdy_q      <= 1'b0;  // rises on the first edge out of reset
    end else begin
      skid_valid <= skid_nxt;
      rdy_q      <= !skid_nxt;
      if (skid_valid) begin
        // rdy_q is low here, so no new word can arrive this edge
        if (out_ready) out_data <= skid_data;
      end else if (acc) begin
        if (!out_valid || out_ready) begin
          out_data  <= in_data;
          out_valid <= 1'b1;
        end else begin
          skid_data <= in_data;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_pipe.sv
// mux_pipe: N-channel, W-bit registered multiplexer with valid/ready on both sides.
//   clk, reset          : clock (rising edge), asynchronous active-high reset
//   in_data [N*W]       : packed channels, channel k at [k*W +: W]
//   in_valid / in_ready : upstream handshake (in_ready registered)
//   sel, rr_mode        : explicit channel index, or round-robin when rr_mode=1
//   out_data/out_valid/out_ready : downstream handshake
//   sel_err             : only with MUX_PIPE_SEL_ERR_EN; one-cycle pulse after an
//                         out-of-range explicit sel was consumed and dropped
//   rr_ptr              : round-robin pointer (debug)
// Macro MUX_PIPE_SEL_ERR_EN enables out-of-range sel dropping and sel_err.
// Without it an out-of-range sel forwards a zero word.
module mux_pipe
  import mux_pipe_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SELW = sel_width(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N*W-1:0]  in_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SELW-1:0] sel,
  input  logic            rr_mode,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
`ifdef MUX_PIPE_SEL_ERR_EN
  output logic            sel_err,
`endif
  output logic [SELW-1:0] rr_ptr
);

  logic [N-1:0][W-1:0] chans;
  sel_mode_e           mode;
  logic [SELW-1:0]     ch;
  logic [W-1:0]        mux_data;
  logic                acc;
  logic                fwd_valid;

  assign chans = in_data;
  assign mode  = sel_mode_e'(rr_mode);
  assign ch    = (mode == SEL_RR) ? rr_ptr : sel;
  assign acc   = in_valid && in_ready;

  // Indices with no matching channel (sel >= N) fall through to zero.
  always_comb begin
    mux_data = W'(RST_DATA);
    for (int k = 0; k < N; k++)
      if (ch == SELW'(k)) mux_data = chans[k];
  end

`ifdef MUX_PIPE_SEL_ERR_EN
  logic sel_oor;
  assign sel_oor   = (mode == SEL_EXPLICIT) && (32'(sel) >= N);
  // Dropped words are still accepted upstream; they just never reach the buffer.
  assign fwd_valid = in_valid && !sel_oor;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sel_err <= 1'b0;
    else       sel_err <= acc && sel_oor;
  end
`else
  assign fwd_valid = in_valid;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rr_ptr <= '0;
    else if (acc && mode == SEL_RR)
      rr_ptr <= (rr_ptr == SELW'(N-1)) ? '0 : rr_ptr + 1'b1;
  end

  mux_skid_buf #(.W(W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_data   (mux_data),
    .in_valid  (fwd_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

endmodule

// File: tb/tb_mux_pipe.sv
// tb_mux_pipe: directed + randomized bench for mux_pipe (N=4 main instance, N=3
// instance for out-of-range sel). Reference model is a FIFO queue of expected
// words plus an integer round-robin pointer.
module tb_mux_pipe;

  localparam int N = 4;
  localparam int W = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  sel;
  logic        rr_mode;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  rr_ptr;

  logic [23:0] in_data3;
  logic        in_valid3, in_ready3, rr_mode3, out_valid3, out_ready3;
  logic [1:0]  sel3, rr_ptr3;
  logic [7:0]  out_data3;
`ifdef MUX_PIPE_SEL_ERR_EN
  logic        sel_err, sel_err3;
`endif

  always #5 clk = ~clk;

  mux_pipe #(.N(N), .W(W)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .rr_mode(rr_mode), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef MUX_PIPE_SEL_ERR_EN
    .sel_err(sel_err),
`endif
    .rr_ptr(rr_ptr)
  );

  mux_pipe #(.N(3), .W(W)) dut3 (
    .clk(clk), .reset(reset), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .sel(sel3), .rr_mode(rr_mode3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready3),
`ifdef MUX_PIPE_SEL_ERR_EN
    .sel_err(sel_err3),
`endif
    .rr_ptr(rr_ptr3)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0] q[$];
  int         mptr = 0;
  bit         first = 1'b1;  // no acceptance before the first edge out of reset
  bit         last_acc;

  function automatic logic [7:0] ref_word();
    int ch;
    logic [31:0] d;
    ch = rr_mode ? mptr : int'(sel);
    d  = in_data;
    return (ch < N) ? 8'(d >> (ch * W)) : 8'h00;
  endfunction

  // One clock: compare outputs to the model mid-cycle, then advance the model.
  task automatic step();
    bit acc, pop;
    logic [7:0] w;
    @(negedge clk);
    if (!first) check("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    check("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    if (q.size() > 0) check("out_data", {24'd0, out_data}, {24'd0, q[0]});
    check("rr_ptr", {30'd0, rr_ptr}, mptr);
`ifdef MUX_PIPE_SEL_ERR_EN
    check("sel_err_main", {31'd0, sel_err}, 32'd0);
`endif
    acc = in_valid && !first && (q.size() < 2);
    pop = (q.size() > 0) && out_ready;
    w   = ref_word();
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc) begin
      q.push_back(w);
      if (rr_mode) mptr = (mptr + 1) % N;
    end
    first    = 1'b0;
    last_acc = acc;
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    mptr  = 0;
    first = 1'b1;
  endtask

  logic [7:0] held, sw_word;

  initial begin
    reset = 1'b1; in_data = '0; in_valid = 1'b0; sel = '0; rr_mode = 1'b0; out_ready = 1'b1;
    in_data3 = '0; in_valid3 = 1'b0; sel3 = '0; rr_mode3 = 1'b0; out_ready3 = 1'b1;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_rr_ptr", {30'd0, rr_ptr}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    step();
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // Single word, explicit sel=2
    in_data = 32'h44332211; sel = 2'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_data", {24'd0, out_data}, 32'h33);
    step();
    check("t1_gone", {31'd0, out_valid}, 32'd0);

    // Back-pressure: A, B, C with out_ready low
    out_ready = 1'b0; sel = 2'd0;
    in_data = 32'h000000A1; in_valid = 1'b1; step();
    in_data = 32'h000000B2; step();
    in_data = 32'h000000C3;
    check("bp_ready_low", {31'd0, in_ready}, 32'd0);
    held = out_data;
    for (int i = 0; i < 3; i++) step();
    check("bp_stable", {24'd0, out_data}, {24'd0, held});
    check("bp_head", {24'd0, out_data}, 32'hA1);
    out_ready = 1'b1;
    last_acc = 1'b0;
    for (int i = 0; i < 10 && !last_acc; i++) step();
    check("bp_c_accepted", {31'd0, last_acc}, 32'd1);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Round-robin: six back-to-back accepts from pointer 0
    rr_mode = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = $urandom;
      step();
    end
    check("rr_end_ptr", {30'd0, rr_ptr}, 32'd2);

    // Mode switch: explicit sel=0 holds the pointer, round-robin resumes at 2
    rr_mode = 1'b0; sel = 2'd0;
    for (int i = 0; i < 3; i++) begin
      in_data = $urandom;
      step();
    end
    check("sw_ptr_held", {30'd0, rr_ptr}, 32'd2);
    rr_mode = 1'b1; in_data = $urandom; sw_word = in_data[23:16];
    step();
    check("sw_ch2", {24'd0, out_data}, {24'd0, sw_word});
    in_valid = 1'b0;
    step(); step();

    // Reset mid-stall with two words buffered
    out_ready = 1'b0; in_valid = 1'b1; rr_mode = 1'b0; sel = 2'd1;
    in_data = 32'h0000D400; step();
    in_data = 32'h0000E500; step();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_data", {24'd0, out_data}, 32'd0);
    check("mid_rst_ptr", {30'd0, rr_ptr}, 32'd0);
    model_reset();
    @(posedge clk); #1 reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);

    // N=3 instance: in-range sanity, then out-of-range sel=3
    in_data3 = 24'h5A_C3_7E; sel3 = 2'd1; in_valid3 = 1'b1;
    @(negedge clk);
    check("n3_ready", {31'd0, in_ready3}, 32'd1);
    @(posedge clk); #1 in_valid3 = 1'b0;
    check("n3_inrange", {24'd0, out_data3}, 32'hC3);
    sel3 = 2'd3; in_data3 = 24'hFF_EE_DD; in_valid3 = 1'b1;
    @(posedge clk); #1 in_valid3 = 1'b0;
`ifdef MUX_PIPE_SEL_ERR_EN
    check("n3_sel_err", {31'd0, sel_err3}, 32'd1);
    check("n3_dropped", {31'd0, out_valid3}, 32'd0);
    check("n3_ptr", {30'd0, rr_ptr3}, 32'd0);
    @(posedge clk); #1;
    check("n3_sel_err_pulse", {31'd0, sel_err3}, 32'd0);
`else
    check("n3_oor_valid", {31'd0, out_valid3}, 32'd1);
    check("n3_oor_zero", {24'd0, out_data3}, 32'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      sel       = 2'($urandom);
      if ($urandom_range(0, 7) == 0) rr_mode = ~rr_mode;
      in_data   = $urandom;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mux_pipe.md
Name: mux_pipe

Overview:
- Parametrised N-channel, W-bit registered multiplexer with valid/ready flow control on both sides.
- A 2-entry skid buffer lets out_ready back-pressure propagate without data loss or combinational ready paths.
- Selection is either explicit (sel) or automatic round-robin (rr_mode).
- Used wherever several same-width producers share one downstream registered consumer.

Parameters:
- N, 4, number of input channels (>=2).
- W, 8, data width per channel in bits (>=1).
- SELW, $clog2(N), width of sel; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  N*W  packed channel data; channel k occupies bits [k*W +: W].
- in_valid  input  1  upstream offers a transfer.
- in_ready  output  1  block can accept; transfer when in_valid && in_ready.
- sel  input  SELW  channel index, used when rr_mode=0.
- rr_mode  input  1  1 = round-robin selection, 0 = explicit sel.
- out_data  output  W  selected data.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
- rr_ptr  output  SELW  current round-robin pointer, for debug.

Behaviour:
- Reset values (asynchronous): out_valid=0, out_data=0, skid entry empty, rr_ptr=0, in_ready=1 from the first clk edge after reset deasserts.
- Channel choice at acceptance: ch = rr_mode ? rr_ptr : sel. Data in_data[ch] is captured on the accepting edge; sel and in_data may change afterwards.
- Latency: accepted word appears on out_data with out_valid=1 the cycle after acceptance when the output stage is empty or draining.
- Storage: output register plus one skid register.
- in_ready is a registered signal: in_ready = !skid_valid. It never depends combinationally on out_ready.
- Output stage empty or out_ready=1 at acceptance: the word goes to the output register.
- Output stage full and out_ready=0 at acceptance: the word goes to the skid register and in_ready drops the next cycle.
- Output pops while skid is full: the skid word moves to the output register that edge and in_ready rises the next cycle.
- Ordering is strict FIFO. No word is dropped or duplicated.
- Simultaneous accept and pop with skid empty: output register reloads with the new word, out_valid stays 1.
- out_data is held stable while out_valid=1 && out_ready=0.
- rr_ptr advances by 1 only on an accepted transfer with rr_mode=1, wrapping from N-1 to 0.
- With rr_mode=0, rr_ptr holds its value. A mode change takes effect at the next acceptance, and round-robin resumes from the held pointer.
- Out-of-range sel (sel >= N, only possible when N is not a power of 2): the transfer is accepted and out_data = 0.
- Reset asserted mid-operation: all stored words are discarded immediately; no partial transfer completes.

Optional Feature:
- Macro: MUX_PIPE_SEL_ERR_EN.
- Defined:
  - Adds output port sel_err (1 bit, reset 0).
  - An accepted transfer with rr_mode=0 and sel >= N is consumed but not forwarded: no out_valid and no pointer change.
  - sel_err pulses high for exactly one cycle on the edge after that acceptance.
- Not defined: no sel_err port; out-of-range sel forwards zero data as above.

Decomposition:
- Package mux_pipe_pkg holds:
  - function sel_width(n), returning max(1, $clog2(n));
  - typedef enum logic {SEL_EXPLICIT, SEL_RR} sel_mode_e;
  - localparam for the reset data value (0).
- Sub-module mux_skid_buf (parameter W) implements the 2-entry valid/ready skid buffer.
- The mux, round-robin pointer and error logic live in mux_pipe.

Test Plan:
- N=4, W=8, rr_mode=0, out_ready=1, sel=2, in_data={8'h44,8'h33,8'h22,8'h11}, one in_valid pulse -> next cycle out_valid=1, out_data=8'h33, then out_valid=0.
- Back-pressure: hold out_ready=0, push 3 words A,B,C -> A and B accepted, in_ready=0 while C waits. Release out_ready -> outputs A, B, C in order, no loss, out_data stable while stalled.
- Round-robin: rr_mode=1, 6 back-to-back accepts with out_ready=1 -> channels 0,1,2,3,0,1 forwarded, rr_ptr ends at 2.
- Mode switch: 2 round-robin accepts (rr_ptr=2), rr_mode=0 with sel=0 for 3 accepts, then rr_mode=1 -> next word comes from channel 2.
- Reset mid-stall: 2 words buffered, assert reset -> out_valid=0, out_data=0, rr_ptr=0 immediately. After deassert, in_ready=1 and the buffered words never appear.
- N=3 with MUX_PIPE_SEL_ERR_EN, sel=3 accepted -> sel_err=1 for one cycle, no out_valid. Without the macro -> out_valid=1, out_data=0.
